// File: rtl/c2h_dsc_scheduler_if.sv
// rtl/c2h_dsc_scheduler_if.sv - XDMA C2H descriptor-bypass port bundle
// master drives descriptors (scheduler); slave is the XDMA bypass input.
interface c2h_dsc_scheduler_if;
   logic        dsc_byp_ready;
   logic        dsc_byp_load;
   logic [63:0] dsc_byp_dst_addr;
   logic [63:0] dsc_byp_src_addr;
   logic [27:0] dsc_byp_len;
   logic [15:0] dsc_byp_ctl;

   modport master (
      input  dsc_byp_ready,
      output dsc_byp_load,
      output dsc_byp_dst_addr,
      output dsc_byp_src_addr,
      output dsc_byp_len,
      output dsc_byp_ctl
   );

   modport slave (
      output dsc_byp_ready,
      input  dsc_byp_load,
      input  dsc_byp_dst_addr,
      input  dsc_byp_src_addr,
      input  dsc_byp_len,
      input  dsc_byp_ctl
   );
endinterface

// File: rtl/c2h_dsc_scheduler.sv
// rtl/c2h_dsc_scheduler.sv - C2H descriptor-bypass scheduler over a host buffer ring
// Issues one descriptor per free buffer within the outstanding limit; retires on C2H tlast.
module c2h_dsc_scheduler #(
   parameter logic [63:0] RING_BASE       = 64'h1_0000_0000,
   parameter logic [27:0] BUF_SIZE        = 28'h1000,
   parameter int          NUM_BUFS        = 16,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          IDXW            = $clog2(NUM_BUFS)
) (
   input  logic                       clk,
   input  logic                       sys_rst,
   input  logic                       enable,
   c2h_dsc_scheduler_if.master        dsc,
   input  logic                       c2h_tvalid,
   input  logic                       c2h_tready,
   input  logic                       c2h_tlast,
   input  logic                       credit_valid,
   input  logic [IDXW:0]              credit_num,
   output logic [IDXW:0]              free_cnt,
   output logic [IDXW:0]              outstanding,
   output logic [IDXW-1:0]            wr_idx,
   output logic [31:0]                desc_issued,
   output logic [31:0]                pkt_done,
   output logic                       err_credit_ovf,
   output logic                       err_cpl_unf
);

   localparam logic [IDXW:0]   NUM_BUFS_W = (IDXW+1)'(NUM_BUFS);
   localparam logic [IDXW:0]   MAX_OUT_W  = (IDXW+1)'(MAX_OUTSTANDING);
   localparam logic [IDXW+2:0] NUM_BUFS_X = (IDXW+3)'(NUM_BUFS);

   typedef enum logic [1:0] {IDLE, LOAD, GAP} state_t;

   state_t          state;
   state_t          state_next;
   logic            issue;
   logic            cpl;
   logic [IDXW+2:0] free_sum;
   logic [IDXW:0]   free_next;
   logic [IDXW:0]   out_next;
   logic            ovf_next;
   logic            unf_next;

   always_ff @(posedge clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (enable && free_cnt != '0 && outstanding < MAX_OUT_W && dsc.dsc_byp_ready) begin
               issue      = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD:    state_next = GAP;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Issue, completion and credit all fold into a single update per cycle.
   always_comb begin
      cpl       = c2h_tvalid && c2h_tready && c2h_tlast;
      free_sum  = (IDXW+3)'(free_cnt) - (IDXW+3)'(issue)
                + (credit_valid ? (IDXW+3)'(credit_num) : '0);
      ovf_next  = free_sum > NUM_BUFS_X;
      free_next = ovf_next ? NUM_BUFS_W : free_sum[IDXW:0];
      unf_next  = cpl && !issue && outstanding == '0;
      out_next  = unf_next ? '0 : outstanding + (IDXW+1)'(issue) - (IDXW+1)'(cpl);
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         dsc.dsc_byp_dst_addr <= RING_BASE;
         free_cnt             <= NUM_BUFS_W;
         outstanding          <= '0;
         wr_idx               <= '0;
         desc_issued          <= '0;
         pkt_done             <= '0;
         err_credit_ovf       <= 1'b0;
         err_cpl_unf          <= 1'b0;
      end else begin
         if (issue) begin
            dsc.dsc_byp_dst_addr <= RING_BASE + 64'(wr_idx) * 64'(BUF_SIZE);
            wr_idx               <= wr_idx + IDXW'(1);
            desc_issued          <= desc_issued + 32'd1;
         end
         if (cpl) pkt_done <= pkt_done + 32'd1;
         free_cnt       <= free_next;
         outstanding    <= out_next;
         err_credit_ovf <= ovf_next;
         err_cpl_unf    <= unf_next;
      end
   end

   assign dsc.dsc_byp_load     = (state == LOAD);
   assign dsc.dsc_byp_src_addr = 64'd0;
   assign dsc.dsc_byp_len      = BUF_SIZE;
   assign dsc.dsc_byp_ctl      = 16'd0;

endmodule

// File: tb/tb_c2h_dsc_scheduler.sv
// tb/tb_c2h_dsc_scheduler.sv - self-checking bench for c2h_dsc_scheduler
// Directed scenarios plus randomized traffic against a ring/credit reference model.
module tb_c2h_dsc_scheduler;
   localparam logic [63:0] RING_BASE = 64'h1_0000_0000;
   localparam logic [27:0] BUF_SIZE  = 28'h1000;
   localparam int          NUM_BUFS  = 16;
   localparam int          MAX_OUT   = 4;

   logic        user_clk_250 = 1'b0;
   logic        sys_rst      = 1'b1;
   logic        enable       = 1'b0;
   logic        c2h_tvalid   = 1'b0;
   logic        c2h_tready   = 1'b0;
   logic        c2h_tlast    = 1'b0;
   logic        credit_valid = 1'b0;
   logic [4:0]  credit_num   = '0;
   logic [4:0]  free_cnt;
   logic [4:0]  outstanding;
   logic [3:0]  wr_idx;
   logic [31:0] desc_issued;
   logic [31:0] pkt_done;
   logic        err_credit_ovf;
   logic        err_cpl_unf;

   c2h_dsc_scheduler_if dsc_if ();

   c2h_dsc_scheduler #(
      .RING_BASE       (RING_BASE),
      .BUF_SIZE        (BUF_SIZE),
      .NUM_BUFS        (NUM_BUFS),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk            (user_clk_250),
      .sys_rst        (sys_rst),
      .enable         (enable),
      .dsc            (dsc_if.master),
      .c2h_tvalid     (c2h_tvalid),
      .c2h_tready     (c2h_tready),
      .c2h_tlast      (c2h_tlast),
      .credit_valid   (credit_valid),
      .credit_num     (credit_num),
      .free_cnt       (free_cnt),
      .outstanding    (outstanding),
      .wr_idx         (wr_idx),
      .desc_issued    (desc_issued),
      .pkt_done       (pkt_done),
      .err_credit_ovf (err_credit_ovf),
      .err_cpl_unf    (err_cpl_unf)
   );

   always #5 user_clk_250 = ~user_clk_250;

   int checks = 0;
   int errors = 0;

   // Reference model: buffer pool, in-flight count, ring position, and the
   // number of cycles the scheduler is still busy with the last descriptor.
   int          m_free = NUM_BUFS;
   int          m_out  = 0;
   int          m_idx  = 0;
   int          m_busy = 0;
   logic [31:0] m_iss  = '0;
   logic [31:0] m_done = '0;
   logic        e_load = 1'b0;
   logic        e_ovf  = 1'b0;
   logic        e_unf  = 1'b0;
   logic [63:0] e_dst  = RING_BASE;

   function automatic logic eligible();
      return enable && dsc_if.dsc_byp_ready && m_free != 0 && m_out < MAX_OUT && m_busy == 0;
   endfunction

   task automatic step();
      logic issue;
      logic cpl;
      int   sum;
      issue = !sys_rst && eligible();
      cpl   = c2h_tvalid && c2h_tready && c2h_tlast;
      @(posedge user_clk_250);
      #1;
      if (sys_rst) begin
         m_free = NUM_BUFS; m_out = 0; m_idx = 0; m_busy = 0;
         m_iss = '0; m_done = '0;
         e_load = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_dst = RING_BASE;
      end else begin
         e_load = issue;
         if (issue) begin
            e_dst = RING_BASE + 64'(m_idx) * 64'(BUF_SIZE);
            m_idx = (m_idx + 1) % NUM_BUFS;
            m_iss = m_iss + 32'd1;
         end
         m_busy = issue ? 2 : (m_busy > 0 ? m_busy - 1 : 0);
         sum    = m_free - int'(issue) + (credit_valid ? int'(credit_num) : 0);
         e_ovf  = sum > NUM_BUFS;
         m_free = e_ovf ? NUM_BUFS : sum;
         e_unf  = cpl && (m_out + int'(issue) == 0);
         m_out  = e_unf ? 0 : m_out + int'(issue) - int'(cpl);
         if (cpl) m_done = m_done + 32'd1;
      end
   endtask

   task automatic clear_inputs();
      enable = 1'b0; dsc_if.dsc_byp_ready = 1'b0;
      c2h_tvalid = 1'b0; c2h_tready = 1'b0; c2h_tlast = 1'b0;
      credit_valid = 1'b0; credit_num = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      sys_rst = 1'b1;
      step();
      step();
      sys_rst = 1'b0;
      checks += 11;
      if (dsc_if.dsc_byp_load !== 1'b0) begin errors++; $display("FAIL reset_load got %0b want 0", dsc_if.dsc_byp_load); end
      if (dsc_if.dsc_byp_dst_addr !== 64'h1_0000_0000) begin errors++; $display("FAIL reset_dst got %h want 100000000", dsc_if.dsc_byp_dst_addr); end
      if (dsc_if.dsc_byp_src_addr !== 64'd0) begin errors++; $display("FAIL reset_src got %h want 0", dsc_if.dsc_byp_src_addr); end
      if (dsc_if.dsc_byp_len !== 28'h1000) begin errors++; $display("FAIL reset_len got %h want 1000", dsc_if.dsc_byp_len); end
      if (dsc_if.dsc_byp_ctl !== 16'd0) begin errors++; $display("FAIL reset_ctl got %h want 0", dsc_if.dsc_byp_ctl); end
      if (free_cnt !== 5'd16) begin errors++; $display("FAIL reset_free got %0d want 16", free_cnt); end
      if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_out got %0d want 0", outstanding); end
      if (wr_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", wr_idx); end
      if (desc_issued !== 32'd0) begin errors++; $display("FAIL reset_issued got %0d want 0", desc_issued); end
      if (pkt_done !== 32'd0) begin errors++; $display("FAIL reset_done got %0d want 0", pkt_done); end
      if ({err_credit_ovf, err_cpl_unf} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {err_credit_ovf, err_cpl_unf}); end
   endtask

   task automatic test_initial_burst();
      logic [63:0] exp_a [4];
      logic [63:0] got [$];
      exp_a = '{64'h1_0000_0000, 64'h1_0000_1000, 64'h1_0000_2000, 64'h1_0000_3000};
      do_reset();
      enable = 1'b1; dsc_if.dsc_byp_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step();
         if (dsc_if.dsc_byp_load === 1'b1) got.push_back(dsc_if.dsc_byp_dst_addr);
      end
      checks++;
      if (got.size() != 4) begin errors++; $display("FAIL burst_count got %0d want 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_a[i]) begin errors++; $display("FAIL burst_addr%0d got %h want %h", i, got[i], exp_a[i]); end
      end
      checks += 3;
      if (dsc_if.dsc_byp_load !== 1'b0) begin errors++; $display("FAIL burst_load_idle got %0b want 0", dsc_if.dsc_byp_load); end
      if (outstanding !== 5'd4) begin errors++; $display("FAIL burst_out got %0d want 4", outstanding); end
      if (free_cnt !== 5'd12) begin errors++; $display("FAIL burst_free got %0d want 12", free_cnt); end
   endtask

   task automatic test_wrap();
      int   nloads;
      int   cyc;
      logic wrapped;
      logic over;
      logic [3:0] prev_idx;
      logic [63:0] dst17;
      nloads = int'(m_iss);
      wrapped = 1'b0; over = 1'b0; dst17 = '1; prev_idx = wr_idx;
      cyc = 0;
      while (nloads < 17 && cyc < 400) begin
         c2h_tvalid = (cyc % 10 == 9); c2h_tready = c2h_tvalid; c2h_tlast = c2h_tvalid;
         credit_valid = (cyc % 10 == 0) && cyc > 0; credit_num = 5'd1;
         step();
         cyc++;
         if (dsc_if.dsc_byp_load === 1'b1) begin
            nloads++;
            if (nloads == 17) dst17 = dsc_if.dsc_byp_dst_addr;
         end
         if (prev_idx == 4'd15 && wr_idx == 4'd0) wrapped = 1'b1;
         prev_idx = wr_idx;
         if (desc_issued - pkt_done > 32'd4) over = 1'b1;
      end
      clear_inputs();
      checks += 5;
      if (nloads < 17) begin errors++; $display("FAIL wrap_timeout got %0d loads want 17", nloads); end
      if (dst17 !== 64'h1_0000_0000) begin errors++; $display("FAIL wrap_dst17 got %h want 100000000", dst17); end
      if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_idx got %0b want 1", wrapped); end
      if (over !== 1'b0) begin errors++; $display("FAIL wrap_inflight got %0b want 0", over); end
      if (outstanding !== 5'(m_out)) begin errors++; $display("FAIL wrap_out got %0d want %0d", outstanding, m_out); end
   endtask

   task automatic test_simultaneous();
      logic hit;
      hit = 1'b0;
      do_reset();
      enable = 1'b1; dsc_if.dsc_byp_ready = 1'b1;
      for (int i = 0; i < 30 && !hit; i++) begin
         if (m_out == 2 && eligible()) begin
            c2h_tvalid = 1'b1; c2h_tready = 1'b1; c2h_tlast = 1'b1;
            hit = 1'b1;
         end
         step();
         c2h_tvalid = 1'b0; c2h_tready = 1'b0; c2h_tlast = 1'b0;
      end
      checks += 3;
      if (hit !== 1'b1) begin errors++; $display("FAIL simul_reached got %0b want 1", hit); end
      if (outstanding !== 5'd2) begin errors++; $display("FAIL simul_out got %0d want 2", outstanding); end
      if (dsc_if.dsc_byp_load !== 1'b1) begin errors++; $display("FAIL simul_load got %0b want 1", dsc_if.dsc_byp_load); end

      do_reset();
      enable = 1'b1; dsc_if.dsc_byp_ready = 1'b1;
      for (int i = 0; i < 30 && m_iss != 32'd2; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (free_cnt !== 5'd14) begin errors++; $display("FAIL credit_pre got %0d want 14", free_cnt); end
      credit_valid = 1'b1; credit_num = 5'd5;
      step();
      credit_valid = 1'b0; credit_num = '0;
      checks += 3;
      if (free_cnt !== 5'd16) begin errors++; $display("FAIL credit_clamp got %0d want 16", free_cnt); end
      if (err_credit_ovf !== 1'b1) begin errors++; $display("FAIL credit_ovf got %0b want 1", err_credit_ovf); end
      step();
      if (err_credit_ovf !== 1'b0) begin errors++; $display("FAIL credit_ovf_width got %0b want 0", err_credit_ovf); end
   endtask

   task automatic test_underflow();
      do_reset();
      c2h_tvalid = 1'b1; c2h_tready = 1'b1; c2h_tlast = 1'b1;
      step();
      c2h_tvalid = 1'b0; c2h_tready = 1'b0; c2h_tlast = 1'b0;
      checks += 3;
      if (err_cpl_unf !== 1'b1) begin errors++; $display("FAIL unf_pulse got %0b want 1", err_cpl_unf); end
      if (outstanding !== 5'd0) begin errors++; $display("FAIL unf_out got %0d want 0", outstanding); end
      if (pkt_done !== 32'd1) begin errors++; $display("FAIL unf_done got %0d want 1", pkt_done); end
      c2h_tvalid = 1'b1; c2h_tready = 1'b0; c2h_tlast = 1'b1;
      step();
      clear_inputs();
      checks += 2;
      if (err_cpl_unf !== 1'b0) begin errors++; $display("FAIL unf_width got %0b want 0", err_cpl_unf); end
      if (pkt_done !== 32'd1) begin errors++; $display("FAIL notready_done got %0d want 1", pkt_done); end
   endtask

   task automatic test_ready_low();
      int loads;
      loads = 0;
      do_reset();
      enable = 1'b1; dsc_if.dsc_byp_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dsc_if.dsc_byp_load !== 1'b0) loads++;
      end
      checks++;
      if (loads != 0) begin errors++; $display("FAIL ready_low_loads got %0d want 0", loads); end
      dsc_if.dsc_byp_ready = 1'b1;
      step();
      checks++;
      if (dsc_if.dsc_byp_load !== 1'b1) begin errors++; $display("FAIL ready_rise_load got %0b want 1", dsc_if.dsc_byp_load); end
      clear_inputs();
   endtask

   task automatic test_reset_in_load();
      logic seen;
      seen = 1'b0;
      do_reset();
      enable = 1'b1; dsc_if.dsc_byp_ready = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (dsc_if.dsc_byp_load === 1'b1) seen = 1'b1;
      end
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      clear_inputs();
      checks += 5;
      if (seen !== 1'b1) begin errors++; $display("FAIL rstload_seen got %0b want 1", seen); end
      if (dsc_if.dsc_byp_load !== 1'b0) begin errors++; $display("FAIL rstload_load got %0b want 0", dsc_if.dsc_byp_load); end
      if (free_cnt !== 5'd16) begin errors++; $display("FAIL rstload_free got %0d want 16", free_cnt); end
      if (outstanding !== 5'd0) begin errors++; $display("FAIL rstload_out got %0d want 0", outstanding); end
      if (wr_idx !== 4'd0) begin errors++; $display("FAIL rstload_idx got %0d want 0", wr_idx); end
   endtask

   task automatic test_enable_drop();
      logic seen;
      int   loads;
      seen = 1'b0; loads = 0;
      do_reset();
      enable = 1'b1; dsc_if.dsc_byp_ready = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (dsc_if.dsc_byp_load === 1'b1) seen = 1'b1;
      end
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dsc_if.dsc_byp_load !== 1'b0) loads++;
      end
      clear_inputs();
      checks += 3;
      if (seen !== 1'b1) begin errors++; $display("FAIL endrop_seen got %0b want 1", seen); end
      if (loads != 0) begin errors++; $display("FAIL endrop_loads got %0d want 0", loads); end
      if (desc_issued !== 32'd1) begin errors++; $display("FAIL endrop_issued got %0d want 1", desc_issued); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         sys_rst              = ($urandom_range(0, 499) == 0);
         enable               = ($urandom_range(0, 9) != 0);
         dsc_if.dsc_byp_ready = ($urandom_range(0, 3) != 0);
         c2h_tvalid           = ($urandom_range(0, 2) == 0);
         c2h_tready           = ($urandom_range(0, 3) != 0);
         c2h_tlast            = ($urandom_range(0, 1) == 0);
         credit_valid         = ($urandom_range(0, 5) == 0);
         credit_num           = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         step();
         checks += 9;
         if (dsc_if.dsc_byp_load !== e_load) begin errors++; $display("FAIL rnd_load cyc %0d got %0b want %0b", i, dsc_if.dsc_byp_load, e_load); end
         if (dsc_if.dsc_byp_dst_addr !== e_dst) begin errors++; $display("FAIL rnd_dst cyc %0d got %h want %h", i, dsc_if.dsc_byp_dst_addr, e_dst); end
         if (free_cnt !== 5'(m_free)) begin errors++; $display("FAIL rnd_free cyc %0d got %0d want %0d", i, free_cnt, m_free); end
         if (outstanding !== 5'(m_out)) begin errors++; $display("FAIL rnd_out cyc %0d got %0d want %0d", i, outstanding, m_out); end
         if (wr_idx !== 4'(m_idx)) begin errors++; $display("FAIL rnd_idx cyc %0d got %0d want %0d", i, wr_idx, m_idx); end
         if (desc_issued !== m_iss) begin errors++; $display("FAIL rnd_issued cyc %0d got %0d want %0d", i, desc_issued, m_iss); end
         if (pkt_done !== m_done) begin errors++; $display("FAIL rnd_done cyc %0d got %0d want %0d", i, pkt_done, m_done); end
         if (err_credit_ovf !== e_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %0b want %0b", i, err_credit_ovf, e_ovf); end
         if (err_cpl_unf !== e_unf) begin errors++; $display("FAIL rnd_unf cyc %0d got %0b want %0b", i, err_cpl_unf, e_unf); end
      end
      sys_rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_initial_burst();
      test_wrap();
      test_simultaneous();
      test_underflow();
      test_ready_low();
      test_reset_in_load();
      test_enable_drop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/c2h_dsc_scheduler.md
# c2h_dsc_scheduler

Sequences the XDMA C2H descriptor-bypass port, replacing a free-running "load whenever ready" loop. The scheduler keeps a ring of NUM_BUFS host buffers of BUF_SIZE bytes each, starting at RING_BASE. It issues one bypass descriptor per buffer that is free and within the outstanding limit, and it retires descriptors by counting C2H packet ends. It sits between the PCIe block (`dsc_bypass_c2h_*`, `S_AXIS_C2H_*`) and the host-credit path, in the `user_clk_250` domain.

## Interface
- RING_BASE, 64'h100000000, host physical address of buffer 0
- BUF_SIZE, 28'h1000, bytes per buffer; also the descriptor length
- NUM_BUFS, 16, ring depth; power of two, 2..256
- MAX_OUTSTANDING, 4, maximum number of descriptors issued but not yet completed; 1..NUM_BUFS
- IDXW, $clog2(NUM_BUFS), buffer index width
- clk  in  1  user clock (`user_clk_250`)
- sys_rst  in  1  synchronous, active-high reset
- enable  in  1  link up / driver ready; gates new issues only
- dsc_byp_ready  in  1  XDMA can accept a descriptor
- dsc_byp_load  out  1  descriptor strobe, one cycle wide
- dsc_byp_dst_addr  out  64  RING_BASE + idx*BUF_SIZE
- dsc_byp_src_addr  out  64  constant 0
- dsc_byp_len  out  28  BUF_SIZE
- dsc_byp_ctl  out  16  constant 0
- c2h_tvalid, c2h_tready, c2h_tlast  in  1 each  monitor taps on S_AXIS_C2H
- credit_valid  in  1  host returned buffers
- credit_num  in  IDXW+1  number of buffers returned
- free_cnt  out  IDXW+1  buffers available to issue
- outstanding  out  IDXW+1  descriptors in flight
- wr_idx  out  IDXW  next buffer index to issue
- desc_issued, pkt_done  out  32 each  wrapping event counters
- err_credit_ovf, err_cpl_unf  out  1 each  single-cycle error pulses

## Operation
- Reset values: load=0; dst_addr=RING_BASE; src_addr=0; len=BUF_SIZE; ctl=0; free_cnt=NUM_BUFS; outstanding=0; wr_idx=0; both counters=0; both error pulses=0; FSM in IDLE.
- FSM states: IDLE, LOAD, GAP.
  - IDLE -> LOAD when enable && free_cnt!=0 && outstanding<MAX_OUTSTANDING && dsc_byp_ready.
  - LOAD: load=1 for exactly one cycle; the descriptor is accepted that cycle. LOAD -> GAP unconditionally.
  - GAP -> IDLE after one cycle.
- On the registered IDLE->LOAD transition:
  - dst_addr <= RING_BASE + wr_idx*BUF_SIZE, using 64-bit arithmetic.
  - Counters and indices are updated in the same edge as load rises: wr_idx <= wr_idx+1 (wraps NUM_BUFS-1 -> 0), free_cnt -1, outstanding +1, desc_issued +1.
- Completion is c2h_tvalid && c2h_tready && c2h_tlast. It decrements outstanding and increments pkt_done.
  - If outstanding==0 at completion: pulse err_cpl_unf and hold outstanding at 0; pkt_done still increments.
- Credit: on credit_valid, free_cnt += credit_num.
  - If the result would exceed NUM_BUFS, clamp to NUM_BUFS and pulse err_credit_ovf.
- Simultaneous events resolve in one update:
  - outstanding_next = outstanding + issue - cpl.
  - free_cnt_next = min(free_cnt - issue + credit_num, NUM_BUFS).
  - Issue plus completion in the same cycle leaves outstanding unchanged.
- enable deasserted:
  - No new IDLE->LOAD transition.
  - A LOAD/GAP already in progress completes.
  - Completions and credits continue to be tracked.
- sys_rst mid-operation forces all reset values within one cycle, including deasserting a load that is in flight.

## Timing
- Issue latency: conditions true in cycle N -> load=1 in cycle N+1, with dst_addr valid that same cycle.
- Peak issue rate: one descriptor per 3 cycles (LOAD, GAP, IDLE re-evaluation).
- load never asserts while dsc_byp_ready was low in the previous cycle's evaluation.
- dst_addr, len and ctl are stable whenever load=1.
- Status outputs are registered and reflect updates one cycle after the triggering edge.
- Error pulses are one cycle wide, registered with the same update.
- Counters wrap 32'hFFFFFFFF -> 0 silently.

## Test plan
- Reset then enable=1, ready=1, no completions, NUM_BUFS=16, MAX=4 -> exactly 4 loads with dst_addr 0x100000000, 0x100001000, 0x100002000, 0x100003000; then load stays 0; outstanding=4, free_cnt=12.
- Continue with one tlast beat every 10 cycles and credit_num=1 after each -> wr_idx wraps 15->0; 17th descriptor dst_addr=0x100000000; desc_issued−pkt_done never exceeds 4.
- Issue and completion in the same cycle with outstanding=2 -> outstanding stays 2; credit_num=5 with free_cnt=14 -> free_cnt=16, err_credit_ovf pulses once.
- tlast beat with outstanding=0 -> err_cpl_unf 1 cycle, outstanding=0, pkt_done +1; tlast with tready=0 -> no change.
- dsc_byp_ready held low for 20 cycles -> no load; ready rises at cycle K -> load at K+1.
- sys_rst asserted in the LOAD cycle -> next cycle load=0, free_cnt=16, outstanding=0, wr_idx=0; enable=0 during an issue -> the current load completes and no further loads occur.
